// File: rtl/i2c_register_bank.sv
// Byte-wide register bank serving a peripheral's register read/write handshakes.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | waiting for a write (has priority) or a read request
// ST_WR_ACK   | write done at the entry edge; o_write_ack high this cycle
// ST_RD_WAIT  | read latency down-counter running; abort if enable drops
// ST_RD_VALID | o_read_data held, o_read_valid high until ack or abandon
module i2c_register_bank #(
   parameter int                    NUM_REGS     = 16,
   parameter int                    READ_LATENCY = 1,
   parameter logic [NUM_REGS-1:0]   RO_MASK      = '0,
   parameter logic [NUM_REGS*8-1:0] RESET_VALUES = '0
) (
   input  logic                    i_sys_clk,
   input  logic                    i_rst_n,
   input  logic [7:0]              i_register_address,
   input  logic                    i_read_enable,
   output logic [7:0]              o_read_data,
   output logic                    o_read_valid,
   input  logic                    i_read_ack,
   input  logic [7:0]              i_write_data,
   input  logic                    i_write_valid,
   output logic                    o_write_ack,
   input  logic [NUM_REGS*8-1:0]   i_ro_data,
   output logic [NUM_REGS*8-1:0]   o_regs,
   output logic [NUM_REGS-1:0]     o_write_strobe
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WR_ACK   = 2'd1,
      ST_RD_WAIT  = 2'd2,
      ST_RD_VALID = 2'd3
   } state_t;

   localparam logic [1:0] LAT = 2'(READ_LATENCY);

   state_t              state_q, state_d;
   logic [7:0]          addr_q, addr_d;
   logic [1:0]          wait_cnt_q, wait_cnt_d;
   logic [7:0]          rd_data_q, rd_data_d;
   logic [NUM_REGS-1:0] strobe_q, strobe_d;
   logic [7:0]          regs_q [NUM_REGS];
   logic [7:0]          regs_d [NUM_REGS];
   logic [7:0]          sel_addr;
   logic [7:0]          rd_sel;

   // Read address: live bus address when a zero-latency read is captured from IDLE.
   always_comb begin
      sel_addr = (state_q == ST_IDLE) ? i_register_address : addr_q;
   end

   // Read mux; unmatched addresses (>= NUM_REGS, no wrap) read as zero.
   always_comb begin
      rd_sel = 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (sel_addr == 8'(i)) begin
            rd_sel = RO_MASK[i] ? i_ro_data[8*i +: 8] : regs_q[i];
         end
      end
   end

   // Write decode: RO and out-of-range writes leave storage and strobes untouched.
   always_comb begin
      strobe_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (state_q == ST_IDLE && i_write_valid) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (i_register_address == 8'(i) && !RO_MASK[i]) begin
               regs_d[i]   = i_write_data;
               strobe_d[i] = 1'b1;
            end
         end
      end
   end

   // Next-state logic and read capture.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wait_cnt_d = wait_cnt_q;
      rd_data_d  = rd_data_q;
      case (state_q)
         ST_IDLE: begin
            if (i_write_valid) begin
               addr_d  = i_register_address;
               state_d = ST_WR_ACK;
            end else if (i_read_enable) begin
               addr_d = i_register_address;
               if (LAT == 2'd0) begin
                  rd_data_d = rd_sel;
                  state_d   = ST_RD_VALID;
               end else begin
                  wait_cnt_d = LAT;
                  state_d    = ST_RD_WAIT;
               end
            end
         end
         ST_WR_ACK: begin
            state_d = ST_IDLE;
         end
         ST_RD_WAIT: begin
            if (!i_read_enable) begin
               state_d = ST_IDLE;
            end else if (wait_cnt_q == 2'd1) begin
               rd_data_d = rd_sel;
               state_d   = ST_RD_VALID;
            end else begin
               wait_cnt_d = wait_cnt_q - 2'd1;
            end
         end
         ST_RD_VALID: begin
            if (i_read_ack || !i_read_enable) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, capture and storage registers.
   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= 8'h00;
         wait_cnt_q <= 2'd0;
         rd_data_q  <= 8'h00;
         strobe_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RESET_VALUES[8*i +: 8];
         end
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wait_cnt_q <= wait_cnt_d;
         rd_data_q  <= rd_data_d;
         strobe_q   <= strobe_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_out
      assign o_regs[8*gi +: 8] = RO_MASK[gi] ? 8'h00 : regs_q[gi];
   end

   assign o_read_data    = rd_data_q;
   assign o_read_valid   = (state_q == ST_RD_VALID);
   assign o_write_ack    = (state_q == ST_WR_ACK);
   assign o_write_strobe = strobe_q;

endmodule

// File: tb/tb_i2c_register_bank.sv
// Bench for i2c_register_bank: four instances, one per read latency, share the bus.
module tb_i2c_register_bank;

   localparam int              N        = 16;
   localparam logic [N-1:0]    RO       = 16'h0020;
   localparam logic [N*8-1:0]  RST_VALS = 128'h0000_0000_0000_0000_0000_0000_A500_005A;

   typedef struct {
      int         inst;
      logic [7:0] data;
      int         cyc;
   } rd_exp_t;

   typedef struct {
      logic [N-1:0]   strobe;
      logic [N*8-1:0] regs;
      int             cyc;
   } wr_exp_t;

   logic            clk_sys = 1'b0;
   logic            rst_b;
   logic [7:0]      addr;
   logic [7:0]      wdata;
   logic            wv;
   logic [3:0]      rd_en;
   logic [3:0]      hold;
   logic [3:0]      rd_ack;
   logic [3:0]      rd_valid;
   logic [3:0]      wr_ack;
   logic [7:0]      rd_data [4];
   logic [N*8-1:0]  regs_o [4];
   logic [N-1:0]    strobe [4];
   logic [N*8-1:0]  ro_data = 128'hEEEE_EEEE_EEEE_EEEE_EEEE_77EE_EEEE_EEEE;
   logic [N-1:0]    ro_mask_v = RO;
   logic [N*8-1:0]  rst_vals_v = RST_VALS;

   rd_exp_t    rd_q[$];
   wr_exp_t    wr_q[$];
   logic [7:0] mdl [N];
   int         vecs = 0;
   int         errs = 0;
   int         cyc = 0;
   logic [3:0] will_ack = 4'h0;

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      i2c_register_bank #(
         .NUM_REGS     (N),
         .READ_LATENCY (g),
         .RO_MASK      (RO),
         .RESET_VALUES (RST_VALS)
      ) u_dut (
         .i_sys_clk          (clk_sys),
         .i_rst_n            (rst_b),
         .i_register_address (addr),
         .i_read_enable      (rd_en[g]),
         .o_read_data        (rd_data[g]),
         .o_read_valid       (rd_valid[g]),
         .i_read_ack         (rd_ack[g]),
         .i_write_data       (wdata),
         .i_write_valid      (wv),
         .o_write_ack        (wr_ack[g]),
         .i_ro_data          (ro_data),
         .o_regs             (regs_o[g]),
         .o_write_strobe     (strobe[g])
      );
      assign rd_ack[g] = rd_en[g] & rd_valid[g] & ~hold[g];
   end

   function automatic logic [N*8-1:0] exp_regs();
      logic [N*8-1:0] r = '0;
      for (int i = 0; i < N; i++) begin
         if (!ro_mask_v[i]) r[8*i +: 8] = mdl[i];
      end
      return r;
   endfunction

   function automatic logic [7:0] exp_read(input logic [7:0] a);
      int ai = int'(a);
      if (ai >= N) return 8'h00;
      if (ro_mask_v[ai]) return ro_data[8*ai +: 8];
      return mdl[ai];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) mdl[i] = rst_vals_v[8*i +: 8];
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   // Peripheral side: drop each read enable right after the edge that saw its ack.
   initial begin
      forever begin
         @(posedge clk_sys);
         #1;
         rd_en = rd_en & ~will_ack;
      end
   end

   // Monitor: pops expectations whenever a DUT presents a write ack or a new read valid.
   initial begin
      logic [3:0] ack_prev   = 4'h0;
      logic [3:0] valid_prev = 4'h0;
      wr_exp_t    we;
      int         idx;
      forever begin
         @(negedge clk_sys);
         if (rst_b) begin
            for (int k = 0; k < 4; k++) begin
               if (ack_prev[k]) begin
                  vecs++;
                  if (rd_valid[k]) begin
                     errs++;
                     $display("FAIL valid_after_ack inst%0d: valid=%0b, required 0", k, rd_valid[k]);
                  end
               end
               if (rd_valid[k] && !valid_prev[k]) begin
                  idx = -1;
                  for (int j = 0; j < rd_q.size(); j++) begin
                     if (idx < 0 && rd_q[j].inst == k) idx = j;
                  end
                  vecs++;
                  if (idx < 0) begin
                     errs++;
                     $display("FAIL unexpected_valid inst%0d: valid=1 at cycle %0d, required none", k, cyc);
                  end else begin
                     chk($sformatf("read_data inst%0d", k), 128'(rd_data[k]), 128'(rd_q[idx].data));
                     chk($sformatf("read_cycle inst%0d", k), 128'(cyc), 128'(rd_q[idx].cyc));
                     rd_q.delete(idx);
                  end
               end
            end
            if (wr_ack != 4'h0) begin
               chk("write_ack_all", 128'(wr_ack), 128'(4'hF));
               vecs++;
               if (wr_q.size() == 0) begin
                  errs++;
                  $display("FAIL unexpected_write_ack: ack at cycle %0d, required none", cyc);
               end else begin
                  we = wr_q.pop_front();
                  chk("write_ack_cycle", 128'(cyc), 128'(we.cyc));
                  chk("write_strobe", 128'(strobe[3]), 128'(we.strobe));
                  chk("o_regs", regs_o[3], we.regs);
               end
            end else begin
               chk("stray_strobe", 128'(strobe[3]), 128'(0));
            end
         end
         ack_prev   = rd_ack;
         valid_prev = rd_valid;
         will_ack   = rd_ack;
      end
   end

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      logic [N-1:0] s = '0;
      @(posedge clk_sys);
      #2;
      addr  = a;
      wdata = d;
      wv    = 1'b1;
      if (int'(a) < N && !ro_mask_v[int'(a)]) begin
         mdl[int'(a)] = d;
         s[int'(a)]   = 1'b1;
      end
      wr_q.push_back('{s, exp_regs(), cyc + 1});
      @(posedge clk_sys);
      @(posedge clk_sys);
      #2;
      wv = 1'b0;
   endtask

   task automatic wait_rd_done(input logic [3:0] m);
      int n = 0;
      while ((rd_en & m) != 4'h0 && n < 30) begin
         @(posedge clk_sys);
         #2;
         n++;
      end
      vecs++;
      if ((rd_en & m) != 4'h0) begin
         errs++;
         $display("FAIL read_timeout: pending=%b, required 0000", rd_en & m);
         rd_en = rd_en & ~m;
      end
   endtask

   task automatic do_read(input logic [7:0] a, input logic [3:0] m);
      @(posedge clk_sys);
      #2;
      addr  = a;
      rd_en = rd_en | m;
      for (int k = 0; k < 4; k++) begin
         if (m[k]) rd_q.push_back('{k, exp_read(a), cyc + 1 + k});
      end
      wait_rd_done(m);
   endtask

   // Latency-3 read abandoned during its second wait cycle.
   task automatic do_abort();
      @(posedge clk_sys);
      #2;
      addr  = 8'd3;
      rd_en = rd_en | 4'b1000;
      @(posedge clk_sys);
      @(posedge clk_sys);
      #2;
      rd_en = rd_en & 4'b0111;
      repeat (6) @(posedge clk_sys);
   endtask

   // Write and read raised together: write acked first, read served from IDLE afterwards.
   task automatic do_priority(input logic [7:0] a, input logic [7:0] d);
      @(posedge clk_sys);
      #2;
      addr  = a;
      wdata = d;
      wv    = 1'b1;
      rd_en = rd_en | 4'hF;
      mdl[int'(a)] = d;
      wr_q.push_back('{16'(1) << a, exp_regs(), cyc + 1});
      for (int k = 0; k < 4; k++) rd_q.push_back('{k, d, cyc + 3 + k});
      @(posedge clk_sys);
      @(posedge clk_sys);
      #2;
      wv = 1'b0;
      wait_rd_done(4'hF);
   endtask

   task automatic do_reset_mid_read();
      int n = 0;
      @(posedge clk_sys);
      #2;
      addr  = 8'd3;
      hold  = 4'b1000;
      rd_en = rd_en | 4'b1000;
      rd_q.push_back('{3, exp_read(8'd3), cyc + 4});
      while (!rd_valid[3] && n < 20) begin
         @(negedge clk_sys);
         n++;
      end
      chk("reset_setup_valid", 128'(rd_valid[3]), 128'(1));
      @(negedge clk_sys);
      #3;
      rst_b = 1'b0;
      #1;
      chk("reset_valid_drop", 128'(rd_valid), 128'(0));
      chk("reset_read_data", 128'(rd_data[3]), 128'(0));
      chk("reset_regs", regs_o[3], RST_VALS);
      rd_en = 4'h0;
      hold  = 4'h0;
      model_reset();
      @(posedge clk_sys);
      #2;
      rst_b = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_b = 1'b0;
      rd_en = 4'h0;
      hold  = 4'h0;
      wv    = 1'b0;
      addr  = 8'h00;
      wdata = 8'h00;
      model_reset();
      repeat (3) @(posedge clk_sys);
      #2;
      rst_b = 1'b1;
      @(negedge clk_sys);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("reset_regs inst%0d", k), regs_o[k], RST_VALS);
         chk($sformatf("reset_rdata inst%0d", k), 128'(rd_data[k]), 128'(0));
         chk($sformatf("reset_strobe inst%0d", k), 128'(strobe[k]), 128'(0));
      end
      chk("reset_byte3", 128'(regs_o[3][31:24]), 128'(8'hA5));
      chk("reset_valid", 128'(rd_valid), 128'(0));
      chk("reset_wack", 128'(wr_ack), 128'(0));

      do_write(8'd3, 8'h3C);
      do_read(8'd3, 4'hF);
      do_write(8'd5, 8'h11);
      do_read(8'd5, 4'hF);
      do_write(8'h10, 8'hFF);
      do_write(8'hFF, 8'hFF);
      do_read(8'h10, 4'hF);
      do_read(8'hFF, 4'b0001);
      do_write(8'd15, 8'hC3);
      do_read(8'd15, 4'hF);
      do_write(8'd0, 8'h01);
      do_read(8'd0, 4'b1000);
      do_abort();
      do_write(8'd2, 8'h44);
      do_read(8'd2, 4'hF);
      do_priority(8'd7, 8'h99);
      do_reset_mid_read();
      do_read(8'd3, 4'hF);
      repeat (5) @(posedge clk_sys);

      chk("rd_queue_empty", 128'(rd_q.size()), 128'(0));
      chk("wr_queue_empty", 128'(wr_q.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
